song_reader: RTL and testbench

Sequencer that sits directly upstream of `notes_player`. It walks a song stored in an external synchronous ROM and unpacks each entry into the chord, duration, voice-count and waveform fields. It hands each entry to `notes_player` with a one-cycle `load_new_note` pulse, then waits for `done_with_note` before fetching the next entry. It signals end of song when it reaches a terminator entry or the last slot of the song.

---
 rtl/song_reader.sv | 123 ++++++++++++
 tb/tb_song_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// song_reader: walks one song in an external registered ROM and hands each entry
// to notes_player with a single load_new_note pulse, then waits for done_with_note.
module song_reader #(
  parameter int unsigned ENTRY_BITS = 7,
  parameter int unsigned SONG_BITS  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            play,
  input  logic [SONG_BITS-1:0]            song,
  output logic [SONG_BITS+ENTRY_BITS-1:0] rom_addr,
  input  logic [34:0]                     rom_data,
  input  logic                            done_with_note,
  output logic [5:0]                      note1,
  output logic [5:0]                      note2,
  output logic [5:0]                      note3,
  output logic [5:0]                      note4,
  output logic [5:0]                      duration,
  output logic [1:0]                      num_notes,
  output logic [2:0]                      metadata,
  output logic                            load_new_note,
  output logic                            song_done,
  output logic                            busy
);

  typedef enum logic [2:0] {StIdle, StFetch, StData, StLoad, StWaitNote} state_e;

  state_e                          state_q, state_d;
  logic [ENTRY_BITS-1:0]           entry_q, entry_d;
  logic [SONG_BITS-1:0]            song_q, song_d;
  logic [SONG_BITS+ENTRY_BITS-1:0] rom_addr_q, rom_addr_d;
  logic [34:0]                     fields_q, fields_d;
  logic                            load_q, load_d;
  logic                            done_q, done_d;
  logic                            busy_q, busy_d;
  logic                            is_term;

  // A zero duration marks the end of the song.
  assign is_term = (rom_data[10:5] == 6'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      entry_q    <= '0;
      song_q     <= '0;
      rom_addr_q <= '0;
      fields_q   <= '0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      song_q     <= song_d;
      rom_addr_q <= rom_addr_d;
      fields_q   <= fields_d;
      load_q     <= load_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    song_d  = song_q;
    // A song change restarts from slot 0 and overrides everything else.
    if (state_q != StIdle && song != song_q) begin
      state_d = StFetch;
      song_d  = song;
      entry_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          entry_d = '0;
          if (play) begin
            song_d  = song;
            state_d = StFetch;
          end
        end
        StFetch: begin
          if (play) state_d = StFetch == StFetch ? StData : StData;
        end
        StData: begin
          state_d = is_term ? StIdle : StLoad;
        end
        StLoad: begin
          state_d = StWaitNote;
        end
        StWaitNote: begin
          if (done_with_note) begin
            if (entry_q == '1) begin
              state_d = StIdle;
              entry_d = '0;
            end else begin
              state_d = StFetch;
              entry_d = entry_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered copies of next-state decisions; the only way into
  // IDLE from a busy state is end of song, so that edge is the song_done pulse.
  always_comb begin
    rom_addr_d = {song_d, entry_d};
    fields_d   = fields_q;
    if (state_q == StData && state_d == StLoad) fields_d = rom_data;
    load_d = (state_d == StLoad);
    done_d = (state_q != StIdle) && (state_d == StIdle);
    busy_d = (state_d != StIdle);
  end

  assign rom_addr      = rom_addr_q;
  assign {note1, note2, note3, note4, duration, num_notes, metadata} = fields_q;
  assign load_new_note = load_q;
  assign song_done     = done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: randomized ROM songs, a transaction-level expectation
// queue filled by the driver and drained by a negedge monitor.
module tb_song_reader;

  localparam int EntryBits = 7;
  localparam int SongBits  = 2;
  localparam int Slots     = 1 << EntryBits;
  localparam int AddrBits  = EntryBits + SongBits;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                play = 1'b0;
  logic [SongBits-1:0] song = '0;
  logic [AddrBits-1:0] rom_addr;
  logic [34:0]         rom_data = '0;
  logic                done_with_note = 1'b0;
  logic [5:0]          note1, note2, note3, note4, duration;
  logic [1:0]          num_notes;
  logic [2:0]          metadata;
  logic                load_new_note, song_done, busy;

  always #5 clk = ~clk;

  song_reader #(
    .ENTRY_BITS(EntryBits),
    .SONG_BITS (SongBits)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .play          (play),
    .song          (song),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .done_with_note(done_with_note),
    .note1         (note1),
    .note2         (note2),
    .note3         (note3),
    .note4         (note4),
    .duration      (duration),
    .num_notes     (num_notes),
    .metadata      (metadata),
    .load_new_note (load_new_note),
    .song_done     (song_done),
    .busy          (busy)
  );

  logic [34:0] rom [Slots*4];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [34:0] word;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [34:0] last_word = '0;
  bit          last_is_done;
  int          checks = 0;
  int          errors = 0;
  int          c;
  logic [34:0] dut_word;

  assign dut_word = {note1, note2, note3, note4, duration, num_notes, metadata};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary_and_finish();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AddrBits-1:0] addr_of(input int s, input int idx);
    return AddrBits'(s * Slots + idx);
  endfunction

  function automatic logic [34:0] rand_entry(input bit term);
    logic [63:0] r;
    logic [34:0] w;
    r = {$urandom(), $urandom()};
    w = r[34:0];
    w[10:5] = term ? 6'd0 : 6'($urandom_range(1, 63));
    return w;
  endfunction

  // Expected outcome of fetching slot idx of song s, triggered in cycle base.
  task automatic push_entry(input int s, input int idx, input int base, input int lat);
    exp_t        e;
    logic [34:0] w;
    w     = rom[s * Slots + idx];
    e.cyc = base + lat;
    if (w[10:5] == 6'd0) begin
      e.is_done = 1'b1;
      e.word    = last_word;
    end else begin
      e.is_done = 1'b0;
      e.word    = w;
      last_word = w;
    end
    last_is_done = e.is_done;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int at);
    exp_t e;
    e.is_done    = 1'b1;
    e.cyc        = at;
    e.word       = last_word;
    last_is_done = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic wait_pulse(input bit want_done, input string name);
    for (int i = 0; i < 400; i++) begin
      if (want_done ? song_done : load_new_note) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL %s: no pulse within 400 cycles, required one", name);
    summary_and_finish();
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_rom_addr"}, 64'(rom_addr), 64'd0);
    check({pfx, "_fields"}, 64'(dut_word), 64'd0);
    check({pfx, "_load"}, 64'(load_new_note), 64'd0);
    check({pfx, "_song_done"}, 64'(song_done), 64'd0);
    check({pfx, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Play song s to its end; gaps are cycles from each load to done_with_note.
  // At slot pause_idx, play is dropped before the note finishes.
  task automatic run_song(input int s, input int gmin, input int gmax, input int pause_idx);
    int idx;
    int base;
    song = SongBits'(s);
    play = 1'b1;
    base = cyc;
    push_entry(s, 0, base, 3);
    tick();
    check("start_rom_addr", 64'(rom_addr), 64'(addr_of(s, 0)));
    check("start_busy", 64'(busy), 64'd1);
    idx = 0;
    while (!last_is_done) begin
      wait_pulse(1'b0, "load_wait");
      repeat ($urandom_range(gmin, gmax)) tick();
      if (idx == pause_idx) begin
        play = 1'b0;
        tick();
        done_with_note = 1'b1;
        tick();
        done_with_note = 1'b0;
        repeat (10) tick();
        check("pause_rom_addr", 64'(rom_addr), 64'(addr_of(s, idx + 1)));
        check("pause_busy", 64'(busy), 64'd1);
        play = 1'b1;
        base = cyc;
        push_entry(s, idx + 1, base, 2);
      end else begin
        done_with_note = 1'b1;
        base = cyc;
        if (idx == Slots - 1) push_done(base + 1);
        else push_entry(s, idx + 1, base, 3);
        tick();
        done_with_note = 1'b0;
        if (idx != Slots - 1) check("fetch_rom_addr", 64'(rom_addr), 64'(addr_of(s, idx + 1)));
      end
      idx++;
    end
    wait_pulse(1'b1, "song_done_wait");
    play = 1'b0;
    tick();
  endtask

  // Every load/song_done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (load_new_note || song_done) begin
      check("pulse_exclusive", 64'(load_new_note & song_done), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: cycle %0d load=%0b song_done=%0b, required no pulse",
                 cyc, load_new_note, song_done);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", 64'(song_done), 64'(mon_e.is_done));
        check("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("fields", 64'(dut_word), 64'(mon_e.word));
        check("busy_at_pulse", 64'(busy), 64'(!mon_e.is_done));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int t3;
    t0 = $urandom_range(1, 5);
    t3 = $urandom_range(2, 8);
    for (int i = 0; i < Slots; i++) begin
      rom[0 * Slots + i] = rand_entry(i == t0);
      rom[1 * Slots + i] = rand_entry(i == 3);
      rom[2 * Slots + i] = rand_entry(1'b0);
      rom[3 * Slots + i] = rand_entry(i == t3);
    end
    rom[Slots] = {6'd40, 6'd44, 6'd47, 6'd0, 6'd4, 2'd2, 3'd0};

    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    // Three notes then a terminator, notes finishing 20 cycles after each load.
    run_song(1, 20, 20, -1);

    // done_with_note while idle must be ignored.
    done_with_note = 1'b1;
    tick();
    done_with_note = 1'b0;
    repeat (3) tick();
    check("idle_busy", 64'(busy), 64'd0);

    run_song(0, 1, 4, -1);
    run_song(3, 1, 5, 0);
    // Full 128-slot song: ends at the last slot without wrapping.
    run_song(2, 1, 2, -1);

    // Song change coincident with done_with_note.
    song = 2'd1;
    play = 1'b1;
    c = cyc;
    push_entry(1, 0, c, 3);
    tick();
    wait_pulse(1'b0, "change_first_load");
    tick();
    song = 2'd2;
    done_with_note = 1'b1;
    c = cyc;
    push_entry(2, 0, c, 3);
    tick();
    done_with_note = 1'b0;
    check("change_rom_addr", 64'(rom_addr), 64'h100);
    wait_pulse(1'b0, "change_new_load");
    tick();

    // Reset in WAIT_NOTE with done_with_note held high.
    reset = 1'b1;
    done_with_note = 1'b1;
    play = 1'b0;
    tick();
    check_zero("mid_reset");
    tick();
    reset = 1'b0;
    done_with_note = 1'b0;
    last_word = '0;
    repeat (5) tick();
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_rom_addr", 64'(rom_addr), 64'd0);

    run_song(0, 1, 3, -1);

    repeat (5) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    summary_and_finish();
  end

endmodule
